// File: rtl/adc_cal_pkg.sv
// adc_cal_pkg: shared constants, state type and address
// helpers for the ADC gain/offset calibration bank.
package adc_cal_pkg;

  localparam logic [31:0] CAL_DEF_GAIN   = 32'h35a0_0000;
  localparam logic [31:0] CAL_DEF_OFFSET = 32'hc120_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    SWAP,
    STREAM
  } state_t;

  // Channel field width; kept at least 1 so a 1-channel build still has a field.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_cal_stream_tx.sv
// adc_cal_stream_tx: replays the active table as one AXIS beat
// per channel after each swap; done pulses on the tlast handshake.
module adc_cal_stream_tx
  import adc_cal_pkg::*;
#(
  parameter int NUM_CH = 20,
  parameter int DATA_W = 32,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [2*DATA_W-1:0] i_first_data,
  input  logic [2*DATA_W-1:0] i_next_data,
  output logic [CH_W:0]       o_next_ch,
  output logic                o_done,
  output logic [2*DATA_W-1:0] m_axis_tdata,
  output logic [CH_W-1:0]     m_axis_tuser,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready
);

  localparam logic [CH_W:0] LAST_CH = (CH_W+1)'(NUM_CH - 1);
  localparam logic [CH_W:0] CH_ONE  = {{CH_W{1'b0}}, 1'b1};

  logic                r_valid;
  logic                r_last;
  logic [2*DATA_W-1:0] r_data;
  logic [CH_W-1:0]     r_user;
  logic [CH_W:0]       r_nxt;
  logic                w_fire;

  assign w_fire = r_valid & m_axis_tready;

  // Beat 0 is loaded on the swap edge, so it comes from the shadow side.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_user  <= '0;
      r_nxt   <= '0;
    end else if (i_start) begin
      r_valid <= 1'b1;
      r_data  <= i_first_data;
      r_user  <= '0;
      r_last  <= (LAST_CH == '0);
      r_nxt   <= CH_ONE;
    end else if (w_fire) begin
      if (r_last) begin
        r_valid <= 1'b0;
      end else begin
        r_data <= i_next_data;
        r_user <= r_nxt[CH_W-1:0];
        r_last <= (r_nxt == LAST_CH);
        r_nxt  <= r_nxt + CH_ONE;
      end
    end
  end

  assign o_next_ch     = r_nxt;
  assign o_done        = w_fire & r_last;
  assign m_axis_tdata  = r_data;
  assign m_axis_tuser  = r_user;
  assign m_axis_tlast  = r_last;
  assign m_axis_tvalid = r_valid & ~i_rst;

endmodule

// File: rtl/adc_cal_param_bank.sv
// adc_cal_param_bank: shadow/active gain-offset tables with
// frame-aligned atomic commit and post-commit AXIS replay.
module adc_cal_param_bank
  import adc_cal_pkg::*;
#(
  parameter int                NUM_CH      = 20,
  parameter int                DATA_W      = 32,
  parameter bit                SYNC_COMMIT = 1'b1,
  parameter logic [DATA_W-1:0] DEF_GAIN    = DATA_W'(CAL_DEF_GAIN),
  parameter logic [DATA_W-1:0] DEF_OFFSET  = DATA_W'(CAL_DEF_OFFSET),
  localparam int               CH_W        = ch_w(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [CH_W:0]            i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [CH_W+1:0]          i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data,
  input  logic                     i_commit,
  input  logic                     i_sample_sync,
  output logic [NUM_CH*DATA_W-1:0] o_gain,
  output logic [NUM_CH*DATA_W-1:0] o_offset,
  output logic                     o_busy,
  output logic                     o_commit_done,
  output logic                     o_wr_err,
  output logic [2*DATA_W-1:0]      m_axis_tdata,
  output logic [CH_W-1:0]          m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

  logic [DATA_W-1:0] r_sh_g [NUM_CH];
  logic [DATA_W-1:0] r_sh_o [NUM_CH];
  logic [DATA_W-1:0] r_ac_g [NUM_CH];
  logic [DATA_W-1:0] r_ac_o [NUM_CH];

  state_t            r_state;
  logic              r_pend;
  logic              r_done;
  logic              r_wr_err;
  logic [DATA_W-1:0] r_rd_data;

  logic [CH_W-1:0]     w_wr_ch;
  logic [CH_W-1:0]     w_rd_ch;
  logic                w_wr_sel;
  logic                w_rd_sel;
  logic                w_rd_bank;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_start;
  logic                w_tx_done;
  logic [CH_W:0]       w_nxt_ch;
  logic [2*DATA_W-1:0] w_first;
  logic [2*DATA_W-1:0] w_next;

  assign w_wr_ch   = i_wr_addr[CH_W:1];
  assign w_wr_sel  = i_wr_addr[0];
  assign w_rd_bank = i_rd_addr[CH_W+1];
  assign w_rd_ch   = i_rd_addr[CH_W:1];
  assign w_rd_sel  = i_rd_addr[0];
  assign w_wr_ok   = ({1'b0, w_wr_ch} < NCH);
  assign w_rd_ok   = ({1'b0, w_rd_ch} < NCH);
  assign w_start   = (r_state == SWAP);
  assign w_first   = {r_sh_o[0], r_sh_g[0]};
  assign w_next    = (w_nxt_ch < NCH) ?
                     {r_ac_o[w_nxt_ch[CH_W-1:0]],
                      r_ac_g[w_nxt_ch[CH_W-1:0]]} : '0;

  // Swap copies pre-edge shadow, so a same-cycle write stays shadow-only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_sh_g[n] <= DEF_GAIN;
        r_sh_o[n] <= DEF_OFFSET;
        r_ac_g[n] <= DEF_GAIN;
        r_ac_o[n] <= DEF_OFFSET;
      end
    end else begin
      if (w_start) begin
        for (int n = 0; n < NUM_CH; n++) begin
          r_ac_g[n] <= r_sh_g[n];
          r_ac_o[n] <= r_sh_o[n];
        end
      end
      if (i_wr_en && w_wr_ok) begin
        if (w_wr_sel) r_sh_o[w_wr_ch] <= i_wr_data;
        else          r_sh_g[w_wr_ch] <= i_wr_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (!w_rd_ok) begin
      r_rd_data <= '0;
    end else begin
      unique case ({w_rd_bank, w_rd_sel})
        2'b00: r_rd_data <= r_sh_g[w_rd_ch];
        2'b01: r_rd_data <= r_sh_o[w_rd_ch];
        2'b10: r_rd_data <= r_ac_g[w_rd_ch];
        2'b11: r_rd_data <= r_ac_o[w_rd_ch];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_done   <= w_start;
      r_wr_err <= i_wr_en & ~w_wr_ok;
      unique case (r_state)
        IDLE: begin
          if (i_commit) r_state <= SYNC_COMMIT ? WAIT_SYNC : SWAP;
        end
        WAIT_SYNC: begin
          if (i_commit) r_pend <= 1'b1;
          if (i_sample_sync) r_state <= SWAP;
        end
        SWAP: begin
          if (i_commit) r_pend <= 1'b1;
          r_state <= STREAM;
        end
        STREAM: begin
          if (w_tx_done) begin
            r_pend <= 1'b0;
            if (r_pend || i_commit)
              r_state <= SYNC_COMMIT ? WAIT_SYNC : SWAP;
            else
              r_state <= IDLE;
          end else if (i_commit) begin
            r_pend <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  adc_cal_stream_tx #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CH_W   (CH_W)
  ) u_tx (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (w_start),
    .i_first_data  (w_first),
    .i_next_data   (w_next),
    .o_next_ch     (w_nxt_ch),
    .o_done        (w_tx_done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  for (genvar n = 0; n < NUM_CH; n++) begin : g_out
    assign o_gain[n*DATA_W +: DATA_W]   = r_ac_g[n];
    assign o_offset[n*DATA_W +: DATA_W] = r_ac_o[n];
  end

  assign o_rd_data     = r_rd_data;
  assign o_busy        = (r_state != IDLE);
  assign o_commit_done = r_done;
  assign o_wr_err      = r_wr_err;

endmodule
